// File: rtl/bcd_time_keeper.sv
// bcd_time_keeper: free-running 24-hour BCD clock (HH:MM:SS).
// A prescaler divides clk down to a one-second tick. Set mode freezes
// counting and lets the debounced buttons step hours and minutes.
// secPulse marks each tick-driven second advance. minPulse marks any change
// of the minute or hour digits, whether it comes from a carry or a button step.
//
// Handshake: this block has no valid/ready interfaces. incHour/incMin are
// level inputs, and a step happens on each sampled 0->1 transition while
// setMode = 1. Pulses are single-cycle and registered.
module bcd_time_keeper #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       setMode,
  input  logic       incHour,
  input  logic       incMin,
  output logic [3:0] curHour1,
  output logic [3:0] curHour0,
  output logic [3:0] curMin1,
  output logic [3:0] curMin0,
  output logic [3:0] curSec1,
  output logic [3:0] curSec0,
  output logic       secPulse,
  output logic       minPulse
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_TERM = PW'(TICKS_PER_SEC - 1);

  // Two-digit BCD increment that wraps to 00 after reaching max_v.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if (v == max_v) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hour_q, hour_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    sec_q, sec_d;
  logic          prev_inc_hour_q;
  logic          prev_inc_min_q;
  logic          sec_pulse_q, sec_pulse_d;
  logic          min_pulse_q, min_pulse_d;

  logic tick;
  logic hour_step;
  logic min_step;

  // Button edges count only in set mode; edges seen while running are dropped.
  assign tick      = !setMode && (presc_q == PRESC_TERM);
  assign hour_step = setMode && incHour && !prev_inc_hour_q;
  assign min_step  = setMode && incMin && !prev_inc_min_q;

  // Next-state: set-mode stepping, or prescaler plus the single-cycle carry cascade.
  always_comb begin
    presc_d = presc_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    if (setMode) begin
      presc_d = '0;
      sec_d   = 8'h00;
      if (min_step) begin
        min_d = bcd_inc(min_q, 8'h59);
      end
      if (hour_step) begin
        hour_d = bcd_inc(hour_q, 8'h23);
      end
    end else if (tick) begin
      presc_d = '0;
      sec_d   = bcd_inc(sec_q, 8'h59);
      if (sec_q == 8'h59) begin
        min_d = bcd_inc(min_q, 8'h59);
        if (min_q == 8'h59) begin
          hour_d = bcd_inc(hour_q, 8'h23);
        end
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
    sec_pulse_d = tick;
    min_pulse_d = (hour_d != hour_q) || (min_d != min_q);
  end

  // State and pulse registers, plus button history for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q         <= '0;
      hour_q          <= 8'h00;
      min_q           <= 8'h00;
      sec_q           <= 8'h00;
      prev_inc_hour_q <= 1'b0;
      prev_inc_min_q  <= 1'b0;
      sec_pulse_q     <= 1'b0;
      min_pulse_q     <= 1'b0;
    end else begin
      presc_q         <= presc_d;
      hour_q          <= hour_d;
      min_q           <= min_d;
      sec_q           <= sec_d;
      prev_inc_hour_q <= incHour;
      prev_inc_min_q  <= incMin;
      sec_pulse_q     <= sec_pulse_d;
      min_pulse_q     <= min_pulse_d;
    end
  end

  assign curHour1 = hour_q[7:4];
  assign curHour0 = hour_q[3:0];
  assign curMin1  = min_q[7:4];
  assign curMin0  = min_q[3:0];
  assign curSec1  = sec_q[7:4];
  assign curSec0  = sec_q[3:0];
  assign secPulse = sec_pulse_q;
  assign minPulse = min_pulse_q;

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Directed bench for bcd_time_keeper with TICKS_PER_SEC = 4.
// The time is compared as a 24-bit value {HH,MM,SS}, so BCD reads as hex.
module tb_bcd_time_keeper;

  localparam int TPS = 4;

  // Clock and reset.
  logic clk = 1'b0;
  logic reset;
  logic setMode;
  logic incHour;
  logic incMin;
  logic [3:0] curHour1, curHour0, curMin1, curMin0, curSec1, curSec0;
  logic secPulse;
  logic minPulse;
  logic [23:0] t_now;

  always #5 clk = ~clk;

  assign t_now = {curHour1, curHour0, curMin1, curMin0, curSec1, curSec0};

  bcd_time_keeper #(.TICKS_PER_SEC(TPS)) dut (
    .clk      (clk),
    .reset    (reset),
    .setMode  (setMode),
    .incHour  (incHour),
    .incMin   (incMin),
    .curHour1 (curHour1),
    .curHour0 (curHour0),
    .curMin1  (curMin1),
    .curMin0  (curMin0),
    .curSec1  (curSec1),
    .curSec0  (curSec0),
    .secPulse (secPulse),
    .minPulse (minPulse)
  );

  // Scoreboard counters.
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Driver tasks: advance n edges and sample 1 time unit later.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_min();
    incMin = 1'b1;
    cyc(1);
    incMin = 1'b0;
    cyc(1);
  endtask

  task automatic press_hour();
    incHour = 1'b1;
    cyc(1);
    incHour = 1'b0;
    cyc(1);
  endtask

  initial begin
    int sp_cnt, mp_cnt, mp_at, last_sp, bad_gap;
    reset   = 1'b1;
    setMode = 1'b0;
    incHour = 1'b0;
    incMin  = 1'b0;
    #12;
    check("reset_time", 32'(t_now), 32'h000000);
    check("reset_pulses", {30'd0, secPulse, minPulse}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // One free-running minute: 60 ticks, each 4 cycles apart.
    sp_cnt = 0; mp_cnt = 0; mp_at = 0; last_sp = 0; bad_gap = 0;
    for (int i = 1; i <= 240; i++) begin
      cyc(1);
      if (secPulse) begin
        sp_cnt++;
        if (i - last_sp != TPS) bad_gap++;
        last_sp = i;
      end
      if (minPulse) begin
        mp_cnt++;
        mp_at = i;
      end
    end
    check("run_time", 32'(t_now), 32'h000100);
    check("run_sec_pulses", sp_cnt, 60);
    check("run_sec_gap", bad_gap, 0);
    check("run_min_pulses", mp_cnt, 1);
    check("run_min_pulse_at", mp_at, 240);

    // Preload 23:59 and let it run up to midnight.
    setMode = 1'b1;
    repeat (23) press_hour();
    repeat (58) press_min();
    check("preload", 32'(t_now), 32'h235900);
    setMode = 1'b0;
    cyc(236);
    check("pre_midnight", 32'(t_now), 32'h235959);
    cyc(3);
    check("hold_before_tick", 32'(t_now), 32'h235959);
    cyc(1);
    check("midnight", 32'(t_now), 32'h000000);
    check("midnight_pulses", {30'd0, secPulse, minPulse}, 32'd3);

    // Set mode stepping, minute wrap without hour carry, hour wrap.
    setMode = 1'b1;
    incMin  = 1'b1;
    cyc(1);
    check("btn_latency_time", 32'(t_now), 32'h000100);
    check("btn_latency_pulse", 32'(minPulse), 32'd1);
    incMin = 1'b0;
    cyc(1);
    check("btn_pulse_one_cycle", 32'(minPulse), 32'd0);
    repeat (60) press_min();
    check("min_wrap_61", 32'(t_now), 32'h000100);
    repeat (25) press_hour();
    check("hour_wrap_25", 32'(t_now), 32'h010100);

    // Held button steps once; simultaneous edges both apply; run mode ignores.
    incMin = 1'b1;
    cyc(20);
    incMin = 1'b0;
    cyc(1);
    check("held_inc_once", 32'(t_now), 32'h010200);
    incHour = 1'b1;
    incMin  = 1'b1;
    cyc(1);
    check("both_step", 32'(t_now), 32'h020300);
    incHour = 1'b0;
    incMin  = 1'b0;
    cyc(1);
    setMode = 1'b0;
    incMin  = 1'b1;
    cyc(1);
    check("run_inc_ignored_pulse", 32'(minPulse), 32'd0);
    incMin = 1'b0;
    cyc(1);
    check("run_inc_ignored", 32'(t_now), 32'h020300);

    // Reach 12:34:56 then reset asynchronously mid-count.
    setMode = 1'b1;
    cyc(1);
    repeat (10) press_hour();
    repeat (31) press_min();
    setMode = 1'b0;
    cyc(224);
    check("reach_123456", 32'(t_now), 32'h123456);
    reset = 1'b1;
    #1;
    check("async_reset_time", 32'(t_now), 32'h000000);
    check("async_reset_pulse", 32'(secPulse), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(3);
    check("post_reset_no_tick", 32'(secPulse), 32'd0);
    cyc(1);
    check("post_reset_tick", 32'(secPulse), 32'd1);
    check("post_reset_time", 32'(t_now), 32'h000001);

    // Set mode entered on the terminal prescaler edge wins over the tick.
    cyc(228);
    check("reach_58", 32'(t_now), 32'h000058);
    cyc(3);
    setMode = 1'b1;
    cyc(1);
    check("set_wins_time", 32'(t_now), 32'h000000);
    check("set_wins_no_pulse", {30'd0, secPulse, minPulse}, 32'd0);
    setMode = 1'b0;
    cyc(3);
    check("exit_no_early_tick", 32'(secPulse), 32'd0);
    cyc(1);
    check("exit_first_tick", 32'(secPulse), 32'd1);
    check("exit_first_time", 32'(t_now), 32'h000001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
